// File: rtl/masked_sop_pipe_pkg.sv
// Shared types and elaboration helpers for the masked sum-of-products pipeline.
// Node numbering: leaves are 0..N-1, internal node N+k combines nodes 2k and 2k+1, root is RW-1.
package masked_pkg;

    typedef struct packed {
        logic s0;
        logic s1;
    } share_t;

    function automatic int log2_ceil(input int n);
        int r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int lat_of(input int n_terms);
        return 1 + log2_ceil(n_terms);
    endfunction

    function automatic int rw_of(input int n_terms);
        return 2 * n_terms - 1;
    endfunction

    // Tree level of a node; level 0 is the term-AND stage.
    function automatic int node_level(input int n_terms, input int node);
        int base = n_terms;
        int cnt  = n_terms / 2;
        int lvl  = 1;
        if (node < n_terms) begin
            return 0;
        end
        while (node >= base + cnt) begin
            base = base + cnt;
            cnt  = cnt / 2;
            lvl++;
        end
        return lvl;
    endfunction

    localparam int DEFAULT_N_TERMS = 4;
    localparam int DEFAULT_LAT     = lat_of(DEFAULT_N_TERMS);
    localparam int DEFAULT_RW      = rw_of(DEFAULT_N_TERMS);

endpackage

// File: rtl/masked_sop_pipe_if.sv
// Streaming port bundle: two-share A/B term vectors in, two-share X and ~X out.
interface masked_sop_pipe_if #(
    parameter int N_TERMS = masked_pkg::DEFAULT_N_TERMS
);
    import masked_pkg::*;

    localparam int RW = rw_of(N_TERMS);

    logic               in_valid;
    logic               in_ready;
    logic [N_TERMS-1:0] a0;
    logic [N_TERMS-1:0] a1;
    logic [N_TERMS-1:0] b0;
    logic [N_TERMS-1:0] b1;
    logic [RW-1:0]      rnd;
    logic               out_valid;
    logic               out_ready;
    logic               x0;
    logic               x1;
    logic               xbar0;
    logic               xbar1;

    modport master (
        output in_valid, a0, a1, b0, b1, rnd, out_ready,
        input  in_ready, out_valid, x0, x1, xbar0, xbar1
    );

    modport slave (
        input  in_valid, a0, a1, b0, b1, rnd, out_ready,
        output in_ready, out_valid, x0, x1, xbar0, xbar1
    );

endinterface

// File: rtl/masked_sop_pipe_dom_and_reg.sv
// Registered DOM-independent masked AND: the four share products are registered
// before any share-domain XOR, so glitches cannot carry information across domains.
module dom_and_reg
    import masked_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   zeroize,
    input  share_t x,
    input  share_t y,
    input  logic   r,
    output share_t z
);

    logic p00_reg, p01_reg, p10_reg, p11_reg;
    logic p00_next, p01_next, p10_next, p11_next;

    always_comb begin
        p00_next = x.s0 & y.s0;
        p01_next = (x.s0 & y.s1) ^ r;
        p10_next = (x.s1 & y.s0) ^ r;
        p11_next = x.s1 & y.s1;
        if (zeroize) begin
            p00_next = 1'b0;
            p01_next = 1'b0;
            p10_next = 1'b0;
            p11_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p00_reg <= 1'b0;
            p01_reg <= 1'b0;
            p10_reg <= 1'b0;
            p11_reg <= 1'b0;
        end else if (en) begin
            p00_reg <= p00_next;
            p01_reg <= p01_next;
            p10_reg <= p10_next;
            p11_reg <= p11_next;
        end
    end

    assign z.s0 = p00_reg ^ p01_reg;
    assign z.s1 = p11_reg ^ p10_reg;

endmodule

// File: rtl/masked_sop_pipe.sv
// Pipelined two-share masked X = OR_i(A[i] & B[i]) with valid/ready backpressure.
// Optional MASKED_PIPE_ZEROIZE_EN: stages load all-zero shares when their incoming beat is a bubble.
module masked_sop_pipe
    import masked_pkg::*;
#(
    parameter int N_TERMS = DEFAULT_N_TERMS
)(
    input logic               clk,
    input logic               rst,
    masked_sop_pipe_if.slave  bus
);

    localparam int LAT = lat_of(N_TERMS);
    localparam int RW  = rw_of(N_TERMS);

    logic           adv;
    logic [LAT-1:0] valid_reg;
    logic [LAT-1:0] stage_vin;
    logic [LAT-1:0] stage_zero;
    share_t         node_sh [RW];

    // The whole pipe moves in lockstep; only a held output beat can stop it.
    assign adv          = ~(valid_reg[LAT-1] & ~bus.out_ready);
    assign bus.in_ready = adv;
    assign stage_vin    = {valid_reg[LAT-2:0], bus.in_valid};

`ifdef MASKED_PIPE_ZEROIZE_EN
    assign stage_zero = ~stage_vin;
`else
    assign stage_zero = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (adv) begin
            valid_reg <= stage_vin;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_TERMS; gi++) begin : g_leaf
            dom_and_reg u_and (
                .clk     (clk),
                .rst     (rst),
                .en      (adv),
                .zeroize (stage_zero[0]),
                .x       ({bus.a0[gi], bus.a1[gi]}),
                .y       ({bus.b0[gi], bus.b1[gi]}),
                .r       (bus.rnd[gi]),
                .z       (node_sh[gi])
            );
        end

        // Masked OR as u ^ v ^ (u & v); the linear part is registered alongside the AND.
        for (gi = N_TERMS; gi < RW; gi++) begin : g_node
            localparam int LVL = node_level(N_TERMS, gi);
            localparam int CL  = 2 * (gi - N_TERMS);

            share_t and_sh;
            logic   lin0_reg, lin1_reg;
            logic   lin0_next, lin1_next;

            dom_and_reg u_and (
                .clk     (clk),
                .rst     (rst),
                .en      (adv),
                .zeroize (stage_zero[LVL]),
                .x       (node_sh[CL]),
                .y       (node_sh[CL+1]),
                .r       (bus.rnd[gi]),
                .z       (and_sh)
            );

            always_comb begin
                lin0_next = node_sh[CL].s0 ^ node_sh[CL+1].s0;
                lin1_next = node_sh[CL].s1 ^ node_sh[CL+1].s1;
                if (stage_zero[LVL]) begin
                    lin0_next = 1'b0;
                    lin1_next = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lin0_reg <= 1'b0;
                    lin1_reg <= 1'b0;
                end else if (adv) begin
                    lin0_reg <= lin0_next;
                    lin1_reg <= lin1_next;
                end
            end

            assign node_sh[gi] = {lin0_reg ^ and_sh.s0, lin1_reg ^ and_sh.s1};
        end
    endgenerate

    assign bus.out_valid = valid_reg[LAT-1];
    assign bus.x0        = node_sh[RW-1].s0;
    assign bus.x1        = node_sh[RW-1].s1;
    assign bus.xbar0     = ~node_sh[RW-1].s0;
    assign bus.xbar1     = node_sh[RW-1].s1;

endmodule

// File: tb/tb_masked_sop_pipe.sv
// Scoreboard bench for masked_sop_pipe: random shares/randomness against an unmasked OR-of-ANDs model.
module tb_masked_sop_pipe;

    parameter int N_TERMS = 4;
    localparam int LAT_EXP = 1 + $clog2(N_TERMS);
    localparam int RW_EXP  = 2 * N_TERMS - 1;

    typedef struct {
        logic x;
        int   acc_edge;
        bit   chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    masked_sop_pipe_if #(.N_TERMS(N_TERMS)) bus();

    masked_sop_pipe #(.N_TERMS(N_TERMS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   n_beats   = 0;
    int   cyc       = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_x0"},        bus.x0,        0);
        check({tag, "_x1"},        bus.x1,        0);
        check({tag, "_xbar0"},     bus.xbar0,     1);
        check({tag, "_xbar1"},     bus.xbar1,     0);
    endtask

    // Present one beat, hold it until accepted, then record the expected unmasked result.
    task automatic send_shares(input logic [N_TERMS-1:0] sa0, input logic [N_TERMS-1:0] sa1,
                               input logic [N_TERMS-1:0] sb0, input logic [N_TERMS-1:0] sb1,
                               input logic [RW_EXP-1:0] r, input bit chk_lat);
        int   waited = 0;
        exp_t e;
        bus.a0 = sa0; bus.a1 = sa1; bus.b0 = sb0; bus.b1 = sb1;
        bus.rnd = r;
        bus.in_valid = 1'b1;
        forever begin
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", bus.in_ready, 1);
                break;
            end
            @(posedge clk); #1;
        end
        if (bus.in_ready) begin
            e.x        = |((sa0 ^ sa1) & (sb0 ^ sb1));
            e.acc_edge = cyc + 1;
            e.chk_lat  = chk_lat;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [N_TERMS-1:0] av, input logic [N_TERMS-1:0] bv);
        logic [N_TERMS-1:0] ma, mb;
        ma = N_TERMS'($urandom);
        mb = N_TERMS'($urandom);
        send_shares(ma, av ^ ma, mb, bv ^ mb, RW_EXP'($urandom), 1'b0);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            bus.a0  = N_TERMS'($urandom);
            bus.a1  = N_TERMS'($urandom);
            bus.b0  = N_TERMS'($urandom);
            bus.b1  = N_TERMS'($urandom);
            bus.rnd = RW_EXP'($urandom);
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops the scoreboard whenever an output beat is consumed.
    initial begin : monitor
        exp_t       e;
        logic [1:0] held = 2'b00;
        bit         prev_stall = 1'b0;
        logic       xbar_exp;
        logic       nx0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (prev_stall && bus.out_valid) check("stall_hold", {bus.x0, bus.x1}, held);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", bus.out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    xbar_exp = ~e.x;
                    nx0      = ~bus.x0;
                    check("x_value",    bus.x0 ^ bus.x1,       e.x);
                    check("xbar_value", bus.xbar0 ^ bus.xbar1, xbar_exp);
                    check("xbar0_inv",  bus.xbar0,             nx0);
                    check("xbar1_eq",   bus.xbar1,             bus.x1);
                    if (e.chk_lat) check("latency", cyc - e.acc_edge, LAT_EXP - 1);
                    n_beats++;
                    $display("beat %0d: x=%0b xbar=%0b model x=%0b", n_beats,
                             bus.x0 ^ bus.x1, bus.xbar0 ^ bus.xbar1, e.x);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = {bus.x0, bus.x1};
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0]        w;
        logic [N_TERMS-1:0] pa0, pa1, pb0, pb1;
        logic [N_TERMS-1:0] sa0, sa1, sb0, sb1;
        logic [RW_EXP-1:0]  sr;

        bus.in_valid = 1'b0;
        bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
        bus.rnd = '0;
        bus.out_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", bus.in_ready, 1);
        @(posedge clk); #1;
        check("rnd_width", $bits(bus.rnd), RW_EXP);

        // Single unmasked-looking beat with zero randomness; also checks latency.
        send_shares(N_TERMS'(1), '0, N_TERMS'(1), '0, '0, 1'b1);
        idle(LAT_EXP + 2);

        // Genuinely masked shares of A=B=0001 with random randomness.
        w = 16'b1010; pa0 = w[N_TERMS-1:0];
        w = 16'b1011; pa1 = w[N_TERMS-1:0];
        w = 16'b0110; pb0 = w[N_TERMS-1:0];
        w = 16'b0111; pb1 = w[N_TERMS-1:0];
        send_shares(pa0, pa1, pb0, pb1, RW_EXP'($urandom), 1'b1);
        idle(LAT_EXP + 2);

        // Sweep 4-bit A/B pairs back to back with fresh shares each beat.
        for (int i = 0; i < 256; i++) begin
            send_rand(N_TERMS'(i & 15), N_TERMS'((i >> 4) & 15));
        end
        idle(LAT_EXP + 2);

        // Fill the pipe, then hold out_ready low for 5 cycles with a beat waiting.
        for (int i = 0; i < LAT_EXP + 1; i++) begin
            send_rand(N_TERMS'($urandom), N_TERMS'($urandom));
        end
        sa0 = N_TERMS'($urandom); sa1 = N_TERMS'($urandom);
        sb0 = N_TERMS'($urandom); sb1 = N_TERMS'($urandom);
        sr  = RW_EXP'($urandom);
        bus.a0 = sa0; bus.a1 = sa1; bus.b0 = sb0; bus.b1 = sb1; bus.rnd = sr;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("in_ready_stall", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send_shares(sa0, sa1, sb0, sb1, sr, 1'b0);
        idle(LAT_EXP + 2);

        // Randomised traffic with bubbles and random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_rand(N_TERMS'($urandom), N_TERMS'($urandom));
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        idle(LAT_EXP + 3);

        // Reset with two beats in flight: everything discarded, nothing emitted afterwards.
        send_rand(N_TERMS'($urandom), N_TERMS'($urandom));
        send_rand(N_TERMS'($urandom), N_TERMS'($urandom));
        rst = 1'b1;
        #1;
        check_reset_outputs("midstream_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(LAT_EXP + 3);

        // One beat then only bubbles.
        send_rand(N_TERMS'($urandom), N_TERMS'($urandom));
        idle(LAT_EXP + 2);
`ifdef MASKED_PIPE_ZEROIZE_EN
        check("zeroize_x0", bus.x0, 0);
        check("zeroize_x1", bus.x1, 0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
